// File: rtl/pea_token_fifo_if.sv
// Handshake and status bundle for the PEA token FIFO.
// The PEA-side driver uses master; the FIFO uses slave.
interface pea_token_fifo_if #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
);
  localparam int CW = $clog2(buffer_size) + 1;

  logic                 wr_en;
  logic [word_size-1:0] din;
  logic                 rd_en;
  logic                 clr_err;
  logic [word_size-1:0] dout;
  logic [CW-1:0]        population;
  logic [CW-1:0]        free_space;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, population, free_space, full, empty, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, population, free_space, full, empty, overflow, underflow
  );
endinterface

// File: rtl/pea_token_fifo.sv
// Show-ahead synchronous FIFO for the PEA command/data/result/status queues.
// The head word is read combinationally; misuse is latched in sticky error flags.
module pea_token_fifo #(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024
) (
  input  logic               clk,
  input  logic               rst,
  pea_token_fifo_if.slave    bus
);
  localparam int AW = $clog2(buffer_size);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(buffer_size);

  logic [word_size-1:0] mem [buffer_size];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        cnt;
  logic                 ovf, udf;
  logic                 full, empty;
  logic                 wr_ok, rd_ok;
  logic                 ovf_set, udf_set;

  assign full  = (cnt == DEPTH);
  assign empty = (cnt == '0);

  // A full FIFO still accepts a write when a pop frees the slot in the same cycle;
  // an empty FIFO never accepts a pop, even if a write lands in the same cycle.
  assign wr_ok   = bus.wr_en & (~full | bus.rd_en);
  assign rd_ok   = bus.rd_en & ~empty;
  assign ovf_set = bus.wr_en & full & ~bus.rd_en;
  assign udf_set = bus.rd_en & empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // New errors take priority over a same-cycle clear.
      ovf <= ovf_set | (ovf & ~bus.clr_err);
      udf <= udf_set | (udf & ~bus.clr_err);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.din;
  end

  assign bus.dout       = mem[rd_ptr];
  assign bus.population = cnt;
  assign bus.free_space = DEPTH - cnt;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.overflow   = ovf;
  assign bus.underflow  = udf;
endmodule

// File: tb/tb_pea_token_fifo.sv
// Directed bench for pea_token_fifo: a queue-based reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_pea_token_fifo;
  localparam int WS    = 16;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pea_token_fifo_if #(.word_size(WS), .buffer_size(DEPTH)) bus ();

  pea_token_fifo #(.word_size(WS), .buffer_size(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of tokens plus two sticky bits.
  logic [WS-1:0] q[$];
  bit m_ovf, m_udf;

  always @(posedge clk or negedge rst) begin
    int  n;
    bit  do_rd, do_wr;
    if (!rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      n     = q.size();
      do_rd = bus.rd_en && (n > 0);
      do_wr = bus.wr_en && ((n < DEPTH) || bus.rd_en);
      m_ovf = (bus.wr_en && (n == DEPTH) && !bus.rd_en) || (m_ovf && !bus.clr_err);
      m_udf = (bus.rd_en && (n == 0)) || (m_udf && !bus.clr_err);
      if (do_rd) void'(q.pop_front());
      if (do_wr) q.push_back(bus.din);
    end
  end

  always @(negedge clk) begin
    check("model_population", 32'(bus.population), 32'(q.size()));
    check("model_free_space", 32'(bus.free_space), 32'(DEPTH - q.size()));
    check("model_full",       32'(bus.full),       32'(q.size() == DEPTH));
    check("model_empty",      32'(bus.empty),      32'(q.size() == 0));
    check("model_overflow",   32'(bus.overflow),   32'(m_ovf));
    check("model_underflow",  32'(bus.underflow),  32'(m_udf));
    if (q.size() > 0) check("model_dout", 32'(bus.dout), 32'(q[0]));
  end

  task automatic idle();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.clr_err = 1'b0; bus.din = '0;
  endtask

  // Inputs set before the call take effect at the next rising edge; returns 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
    idle();
  endtask

  task automatic push(input logic [WS-1:0] d);
    bus.wr_en = 1'b1; bus.din = d; step();
  endtask

  task automatic pop();
    bus.rd_en = 1'b1; step();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Reset state
    check("rst_population", 32'(bus.population), 32'd0);
    check("rst_free_space", 32'(bus.free_space), 32'd1024);
    check("rst_empty",      32'(bus.empty),      32'd1);
    check("rst_full",       32'(bus.full),       32'd0);
    check("rst_flags",      32'({bus.overflow, bus.underflow}), 32'd0);

    // 1. three writes, show-ahead head
    push(16'h0001);
    check("t1_dout_first", 32'(bus.dout), 32'h0001);
    check("t1_pop1",       32'(bus.population), 32'd1);
    check("t1_empty0",     32'(bus.empty), 32'd0);
    push(16'h0002);
    check("t1_pop2", 32'(bus.population), 32'd2);
    push(16'h0003);
    check("t1_pop3", 32'(bus.population), 32'd3);
    check("t1_head", 32'(bus.dout), 32'h0001);
    pop();
    check("t1_head_after_pop", 32'(bus.dout), 32'h0002);
    pop(); pop();
    check("t1_drained", 32'(bus.empty), 32'd1);

    // 2. fill, then overflow attempt
    for (int i = 0; i < DEPTH; i++) push(16'(i * 7 + 3));
    check("t2_full",       32'(bus.full),       32'd1);
    check("t2_free0",      32'(bus.free_space), 32'd0);
    push(16'hDEAD);
    check("t2_overflow",   32'(bus.overflow),   32'd1);
    check("t2_pop_held",   32'(bus.population), 32'd1024);
    check("t2_head_kept",  32'(bus.dout),       32'h0003);

    // 3. simultaneous push/pop while full
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 16'hBEEF; step();
    check("t3_pop_held",  32'(bus.population), 32'd1024);
    check("t3_head_next", 32'(bus.dout),       32'h000A);
    for (int i = 0; i < DEPTH - 1; i++) pop();
    check("t3_beef_last", 32'(bus.dout),       32'hBEEF);
    check("t3_pop1",      32'(bus.population), 32'd1);
    pop();
    check("t3_empty", 32'(bus.empty), 32'd1);

    // 4. steady streaming across the pointer wrap
    for (int i = 0; i < 5; i++) push(16'h5000 + 16'(i));
    for (int i = 0; i < 1500; i++) begin
      bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 16'h5005 + 16'(i); step();
    end
    check("t4_pop5", 32'(bus.population), 32'd5);
    check("t4_head", 32'(bus.dout),       32'h55DC);
    for (int i = 0; i < 5; i++) pop();
    check("t4_empty", 32'(bus.empty), 32'd1);

    // 5. push+pop on empty: pop rejected, push accepted
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.din = 16'h1234; step();
    check("t5_underflow", 32'(bus.underflow),  32'd1);
    check("t5_pop1",      32'(bus.population), 32'd1);
    check("t5_dout",      32'(bus.dout),       32'h1234);
    check("t5_ovf_sticky", 32'(bus.overflow),  32'd1);
    bus.clr_err = 1'b1; step();
    check("t5_cleared", 32'({bus.overflow, bus.underflow}), 32'd0);
    pop();
    bus.rd_en = 1'b1; bus.clr_err = 1'b1; step();
    check("t5_set_wins", 32'(bus.underflow), 32'd1);
    bus.clr_err = 1'b1; step();
    check("t5_cleared2", 32'(bus.underflow), 32'd0);

    // 6. asynchronous reset mid-cycle with data held
    pop();
    check("t6_udf_pre", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    check("t6_pop10", 32'(bus.population), 32'd10);
    #1 rst = 1'b0;
    #1;
    check("t6_async_pop",   32'(bus.population), 32'd0);
    check("t6_async_empty", 32'(bus.empty),      32'd1);
    check("t6_async_flags", 32'({bus.overflow, bus.underflow}), 32'd0);
    check("t6_async_free",  32'(bus.free_space), 32'd1024);
    step();
    rst = 1'b1;
    push(16'h00AA);
    check("t6_first_after", 32'(bus.dout),       32'h00AA);
    check("t6_pop1",        32'(bus.population), 32'd1);
    pop();
    check("t6_empty", 32'(bus.empty), 32'd1);

    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
